// File: rtl/thcomp_regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : thcomp_regbank_pkg
// Description : Shared constants and types for the threshold-comparator
//               register bank: register offsets relative to the bank base
//               and the CTRL register layout.
// Revision    : 1.0 - initial release
// ============================================================================
package thcomp_regbank_pkg;

    // Register offsets from the bank base address. THRESH[k] sits at
    // c_OFF_THRESH + k and CAPTURE[k] at c_OFF_THRESH + N_CH + k.
    localparam int c_OFF_CTRL     = 0;
    localparam int c_OFF_STATUS   = 1;
    localparam int c_OFF_IRQ_MASK = 2;
    localparam int c_OFF_THRESH   = 3;

    // Implemented CTRL bits; everything above reads back as zero.
    localparam int c_CTRL_W = 3;

    // CTRL layout: bit0 EN, bit1 MODE (1 = peak-hold), bit2 FREEZE.
    typedef struct packed {
        logic freeze;
        logic mode;
        logic en;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/thcomp_chan.sv
`default_nettype none
// ============================================================================
// Module      : thcomp_chan
// Description : One comparator channel: cfg-written threshold, capture
//               register with latest / peak-hold update, and the per-cycle
//               hit pulse that feeds the sticky status in the bank top.
// Ports       : clk, rst_n        clock, async active-low reset
//               en, mode, freeze  CTRL fields shared by all channels
//               thresh_we/_wdata  threshold write from the cfg bus
//               cap_clr           cfg write to CAPTURE (clears it)
//               hw_we, hw_data    sample strobe and value from comparator
//               thresh, capture   current register contents
//               hit               sample >= threshold this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module thcomp_chan #(
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] THRESH_RST = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic              freeze,
    input  logic              thresh_we,
    input  logic [DATA_W-1:0] thresh_wdata,
    input  logic              cap_clr,
    input  logic              hw_we,
    input  logic [DATA_W-1:0] hw_data,
    output logic [DATA_W-1:0] thresh,
    output logic [DATA_W-1:0] capture,
    output logic              hit
);

    logic [DATA_W-1:0] r_thresh;
    logic [DATA_W-1:0] r_capture;
    logic              w_cap_upd;
    logic [DATA_W-1:0] w_cap_next;

    // FREEZE only stops the capture register; hits are still reported.
    assign w_cap_upd  = hw_we & en & ~freeze;
    assign w_cap_next = (mode && (r_capture > hw_data)) ? r_capture : hw_data;

    // Compares against the registered threshold, so a threshold write
    // only affects samples from the following cycle on.
    assign hit = hw_we & en & (hw_data >= r_thresh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thresh <= THRESH_RST;
        end else if (thresh_we) begin
            r_thresh <= thresh_wdata;
        end
    end

    // A cfg clear beats a same-cycle sample; the sample is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_capture <= '0;
        end else if (cap_clr) begin
            r_capture <= '0;
        end else if (w_cap_upd) begin
            r_capture <= w_cap_next;
        end
    end

    assign thresh  = r_thresh;
    assign capture = r_capture;

endmodule
`default_nettype wire

// File: rtl/thcomp_regbank.sv
`default_nettype none
// ============================================================================
// Module      : thcomp_regbank
// Description : Multi-channel threshold-comparator register bank. Decodes
//               the cfg bus, holds CTRL / STATUS / IRQ_MASK, instantiates
//               one thcomp_chan per channel, registers read data and irq.
// Ports       : clk, rst_n                  clock, async active-low reset
//               cfg_we/re/addr/data_in       cfg bus request
//               cfg_data_out, cfg_rvalid     registered read response
//               hw_we, hw_data               per-channel samples
//               thresh_out, capture_out      per-channel register contents
//               hit_status                   sticky hit flags
//               irq                          registered masked OR of status
// Revision    : 1.0 - initial release
// ============================================================================
module thcomp_regbank
    import thcomp_regbank_pkg::*;
#(
    parameter int                N_CH       = 4,
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 8'h20,
    parameter logic [DATA_W-1:0] THRESH_RST = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic                     cfg_re,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [DATA_W-1:0]        cfg_data_in,
    output logic [DATA_W-1:0]        cfg_data_out,
    output logic                     cfg_rvalid,
    input  logic [N_CH-1:0]          hw_we,
    input  logic [N_CH*DATA_W-1:0]   hw_data,
    output logic [N_CH*DATA_W-1:0]   thresh_out,
    output logic [N_CH*DATA_W-1:0]   capture_out,
    output logic [N_CH-1:0]          hit_status,
    output logic                     irq
);

    ctrl_t               r_ctrl;
    logic [N_CH-1:0]     r_status;
    logic [N_CH-1:0]     r_irq_mask;
    logic                r_irq;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rvalid;

    logic                w_in_range;
    logic [ADDR_W-1:0]   w_off;
    logic                w_sel_ctrl;
    logic                w_sel_status;
    logic                w_sel_mask;
    logic [N_CH-1:0]     w_sel_thresh;
    logic [N_CH-1:0]     w_sel_cap;
    logic [N_CH-1:0]     w_hit;
    logic [N_CH-1:0]     w_status_clr;
    logic [DATA_W-1:0]   w_rdata;

    // Addresses below the base must not alias into the map via wraparound.
    assign w_in_range   = (cfg_addr >= BASE_ADDR);
    assign w_off        = cfg_addr - BASE_ADDR;
    assign w_sel_ctrl   = w_in_range && (w_off == ADDR_W'(c_OFF_CTRL));
    assign w_sel_status = w_in_range && (w_off == ADDR_W'(c_OFF_STATUS));
    assign w_sel_mask   = w_in_range && (w_off == ADDR_W'(c_OFF_IRQ_MASK));

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        assign w_sel_thresh[k] = w_in_range && (w_off == ADDR_W'(c_OFF_THRESH + k));
        assign w_sel_cap[k]    = w_in_range && (w_off == ADDR_W'(c_OFF_THRESH + N_CH + k));

        thcomp_chan #(
            .DATA_W     (DATA_W),
            .THRESH_RST (THRESH_RST)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .en           (r_ctrl.en),
            .mode         (r_ctrl.mode),
            .freeze       (r_ctrl.freeze),
            .thresh_we    (cfg_we & w_sel_thresh[k]),
            .thresh_wdata (cfg_data_in),
            .cap_clr      (cfg_we & w_sel_cap[k]),
            .hw_we        (hw_we[k]),
            .hw_data      (hw_data[k*DATA_W +: DATA_W]),
            .thresh       (thresh_out[k*DATA_W +: DATA_W]),
            .capture      (capture_out[k*DATA_W +: DATA_W]),
            .hit          (w_hit[k])
        );
    end

    // W1C mask; OR-ing the hits in afterwards lets a new hit win over a clear.
    assign w_status_clr = (cfg_we && w_sel_status) ? cfg_data_in[N_CH-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl     <= '0;
            r_status   <= '0;
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (cfg_we && w_sel_ctrl) begin
                r_ctrl <= ctrl_t'(cfg_data_in[c_CTRL_W-1:0]);
            end
            if (cfg_we && w_sel_mask) begin
                r_irq_mask <= cfg_data_in[N_CH-1:0];
            end
            r_status <= (r_status & ~w_status_clr) | w_hit;
            r_irq    <= |(r_status & r_irq_mask);
        end
    end

    // Read mux sees pre-write register values, so a same-cycle write is
    // not visible to the read.
    always_comb begin
        w_rdata = '0;
        if (w_sel_ctrl)   w_rdata = DATA_W'(r_ctrl);
        if (w_sel_status) w_rdata = DATA_W'(r_status);
        if (w_sel_mask)   w_rdata = DATA_W'(r_irq_mask);
        for (int k = 0; k < N_CH; k++) begin
            if (w_sel_thresh[k]) w_rdata = thresh_out[k*DATA_W +: DATA_W];
            if (w_sel_cap[k])    w_rdata = capture_out[k*DATA_W +: DATA_W];
        end
    end

    // Read data holds between reads; rvalid is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= cfg_re;
            if (cfg_re) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign cfg_data_out = r_rdata;
    assign cfg_rvalid   = r_rvalid;
    assign hit_status   = r_status;
    assign irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_thcomp_regbank.sv
`default_nettype none
// ============================================================================
// Module      : tb_thcomp_regbank
// Description : Directed self-checking bench for thcomp_regbank. Bus reads
//               push the expected word to a scoreboard queue; a negedge
//               monitor pops and compares whenever cfg_rvalid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_thcomp_regbank;

    localparam int          N_CH   = 4;
    localparam int          DATA_W = 16;
    localparam int          ADDR_W = 8;
    localparam logic [7:0]  BASE   = 8'h20;
    localparam logic [15:0] TR     = 16'd7;

    localparam logic [7:0] A_CTRL   = BASE + 8'd0;
    localparam logic [7:0] A_STATUS = BASE + 8'd1;
    localparam logic [7:0] A_MASK   = BASE + 8'd2;
    localparam logic [7:0] A_TH0    = BASE + 8'd3;
    localparam logic [7:0] A_CAP0   = BASE + 8'd7;

    logic                   clk;
    logic                   rst_n;
    logic                   cfg_we;
    logic                   cfg_re;
    logic [ADDR_W-1:0]      cfg_addr;
    logic [DATA_W-1:0]      cfg_data_in;
    logic [DATA_W-1:0]      cfg_data_out;
    logic                   cfg_rvalid;
    logic [N_CH-1:0]        hw_we;
    logic [N_CH*DATA_W-1:0] hw_data;
    logic [N_CH*DATA_W-1:0] thresh_out;
    logic [N_CH*DATA_W-1:0] capture_out;
    logic [N_CH-1:0]        hit_status;
    logic                   irq;

    thcomp_regbank #(
        .N_CH       (N_CH),
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (BASE),
        .THRESH_RST (TR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we       (cfg_we),
        .cfg_re       (cfg_re),
        .cfg_addr     (cfg_addr),
        .cfg_data_in  (cfg_data_in),
        .cfg_data_out (cfg_data_out),
        .cfg_rvalid   (cfg_rvalid),
        .hw_we        (hw_we),
        .hw_data      (hw_data),
        .thresh_out   (thresh_out),
        .capture_out  (capture_out),
        .hit_status   (hit_status),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int      n_cmp = 0;
    int      n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard side: every rvalid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (cfg_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 64'(cfg_rvalid), 64'd0);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                check($sformatf("rd@%0h", e.addr), 64'(cfg_data_out), 64'(e.data));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        cfg_we      = 1'b1;
        cfg_addr    = a;
        cfg_data_in = d;
        cyc();
        cfg_we      = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] e);
        cfg_re   = 1'b1;
        cfg_addr = a;
        exp_q.push_back('{a, e});
        cyc();
        cfg_re   = 1'b0;
    endtask

    task automatic sample(input int ch, input logic [15:0] v);
        hw_we[ch]              = 1'b1;
        hw_data[ch*DATA_W +: DATA_W] = v;
        cyc();
        hw_we = '0;
    endtask

    function automatic logic [63:0] cap(input int ch);
        return 64'(capture_out[ch*DATA_W +: DATA_W]);
    endfunction

    initial begin
        rst_n       = 1'b0;
        cfg_we      = 1'b0;
        cfg_re      = 1'b0;
        cfg_addr    = '0;
        cfg_data_in = '0;
        hw_we       = '0;
        hw_data     = '0;
        cyc();
        cyc();

        // Reset state
        check("rst_rvalid", 64'(cfg_rvalid), 64'd0);
        check("rst_rdata", 64'(cfg_data_out), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_thresh", thresh_out, {4{TR}});
        check("rst_capture", capture_out, 64'd0);
        rst_n = 1'b1;
        cyc();
        rd(A_CTRL, 16'd0);
        rd(A_STATUS, 16'd0);
        rd(A_MASK, 16'd0);
        for (int k = 0; k < N_CH; k++) rd(A_TH0 + 8'(k), TR);
        for (int k = 0; k < N_CH; k++) rd(A_CAP0 + 8'(k), 16'd0);
        rd(BASE + 8'd11, 16'd0);
        rd(BASE - 8'd1, 16'd0);
        wr(BASE + 8'd11, 16'hFFFF);
        rd(BASE + 8'd11, 16'd0);

        // Latest mode on ch1, hit exactly at threshold
        wr(A_CTRL, 16'h0001);
        wr(A_TH0 + 8'd1, 16'd100);
        sample(1, 16'd99);
        check("ch1_cap_99", cap(1), 64'd99);
        check("ch1_nohit_99", 64'(hit_status), 64'd0);
        sample(1, 16'd100);
        check("ch1_cap_100", cap(1), 64'd100);
        check("ch1_hit_100", 64'(hit_status), 64'h2);
        rd(A_CAP0 + 8'd1, 16'd100);
        rd(A_STATUS, 16'h0002);
        wr(A_STATUS, 16'h000F);
        check("w1c_all", 64'(hit_status), 64'd0);

        // Peak-hold on ch0 and clear-beats-sample
        wr(A_CTRL, 16'h0003);
        sample(0, 16'd5);
        check("pk_5", cap(0), 64'd5);
        sample(0, 16'd9);
        check("pk_9", cap(0), 64'd9);
        sample(0, 16'd3);
        check("pk_3", cap(0), 64'd9);
        cfg_we = 1'b1; cfg_addr = A_CAP0; cfg_data_in = 16'hFFFF;
        hw_we[0] = 1'b1; hw_data[15:0] = 16'd7;
        cyc();
        cfg_we = 1'b0; hw_we = '0;
        check("cap_clr_wins", cap(0), 64'd0);
        check("cap_clr_hit", 64'(hit_status), 64'h1);
        rd(A_CAP0, 16'd0);
        wr(A_STATUS, 16'h0001);

        // Threshold write uses old value in the same cycle
        cfg_we = 1'b1; cfg_addr = A_TH0 + 8'd3; cfg_data_in = 16'd10;
        hw_we[3] = 1'b1; hw_data[63:48] = 16'd8;
        cyc();
        cfg_we = 1'b0; hw_we = '0;
        check("th_old_hit", 64'(hit_status), 64'h8);
        wr(A_STATUS, 16'h0008);
        sample(3, 16'd9);
        check("th_new_nohit", 64'(hit_status), 64'd0);
        check("pk_ch3", cap(3), 64'd9);
        sample(3, 16'd10);
        check("th_new_hit", 64'(hit_status), 64'h8);
        wr(A_STATUS, 16'h0008);

        // Freeze, CTRL read-back masking, irq latency
        wr(A_CTRL, 16'hFFFD);
        rd(A_CTRL, 16'h0005);
        wr(A_TH0 + 8'd2, 16'd50);
        sample(2, 16'd200);
        check("frz_cap", cap(2), 64'd0);
        check("frz_hit", 64'(hit_status), 64'h4);
        check("irq_unmasked", 64'(irq), 64'd0);
        wr(A_MASK, 16'h0004);
        check("irq_lat0", 64'(irq), 64'd0);
        cyc();
        check("irq_set", 64'(irq), 64'd1);

        // W1C racing a new hit, then a clean clear
        wr(A_MASK, 16'h0006);
        sample(1, 16'd150);
        check("st_0110", 64'(hit_status), 64'h6);
        cfg_we = 1'b1; cfg_addr = A_STATUS; cfg_data_in = 16'h0002;
        hw_we[1] = 1'b1; hw_data[31:16] = 16'd120;
        cyc();
        cfg_we = 1'b0; hw_we = '0;
        check("set_wins", 64'(hit_status), 64'h6);
        wr(A_STATUS, 16'h0006);
        check("w1c_clr", 64'(hit_status), 64'd0);
        check("irq_hold", 64'(irq), 64'd1);
        cyc();
        check("irq_drop", 64'(irq), 64'd0);

        // Read returns pre-write value on a same-cycle read+write
        cfg_we = 1'b1; cfg_re = 1'b1; cfg_addr = A_TH0 + 8'd3; cfg_data_in = 16'd20;
        exp_q.push_back('{A_TH0 + 8'd3, 16'd10});
        cyc();
        cfg_we = 1'b0; cfg_re = 1'b0;
        rd(A_TH0 + 8'd3, 16'd20);
        rd(A_MASK, 16'h0006);

        // Reset during a pending read
        sample(2, 16'd200);
        cyc();
        check("pre_rst_irq", 64'(irq), 64'd1);
        cfg_re = 1'b1; cfg_addr = A_CTRL;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_irq", 64'(irq), 64'd0);
        check("mid_rst_status", 64'(hit_status), 64'd0);
        check("mid_rst_thresh", thresh_out, {4{TR}});
        check("mid_rst_capture", capture_out, 64'd0);
        check("mid_rst_rdata", 64'(cfg_data_out), 64'd0);
        check("mid_rst_rvalid", 64'(cfg_rvalid), 64'd0);
        cyc();
        cfg_re = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        rd(A_CTRL, 16'd0);
        rd(A_MASK, 16'd0);

        repeat (3) cyc();
        check("rd_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
